// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline definitions: arbiter state encoding, timeout default,
// and the fetch/decode stage state types used alongside it.
package mem_arbiter_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_GNT_F   = 3'b001,
        ST_GNT_D   = 3'b010,
        ST_DRAIN_F = 3'b011,
        ST_ERR     = 3'b100
    } arb_state_t;

    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } requester_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        DEC_IDLE  = 2'b00,
        DEC_RUN   = 2'b01,
        DEC_STALL = 2'b10
    } decode_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto a single memory port,
// with fetch flush draining and a sticky wait-timeout error state.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 f_readEn,
    input  logic [ADDR_SIZE-1:0] f_addr,
    input  logic                 f_flush,
    output logic                 f_readFin,
    output logic [XLEN-1:0]      f_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    input  logic [XLEN/8-1:0]    d_wstrb,
    output logic                 d_fin,
    output logic [XLEN-1:0]      d_rdata,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wstrb,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_fin,

    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t             state, state_next;
    requester_t             last_served, last_next;
    logic [CNT_W-1:0]       wait_cnt, cnt_next;
    logic                   err_next;
    logic [ADDR_SIZE-1:0]   lat_addr, addr_next;
    logic [XLEN-1:0]        lat_wdata, wdata_next;
    logic [XLEN/8-1:0]      lat_wstrb, wstrb_next;
    logic                   lat_we, we_next;

    logic f_valid, pick_data, timeout_hit;
    logic grant_data, grant_fetch;

    // A flush cancels any fetch request raised in the same cycle.
    assign f_valid     = f_readEn && !f_flush;
    assign pick_data   = d_req && (!f_valid || last_served == SRC_FETCH);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last_served <= SRC_FETCH;
            wait_cnt    <= '0;
            err         <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            lat_we      <= 1'b0;
        end else begin
            state       <= state_next;
            last_served <= last_next;
            wait_cnt    <= cnt_next;
            err         <= err_next;
            lat_addr    <= addr_next;
            lat_wdata   <= wdata_next;
            lat_wstrb   <= wstrb_next;
            lat_we      <= we_next;
        end
    end

    always_comb begin
        state_next  = state;
        last_next   = last_served;
        err_next    = err;
        addr_next   = lat_addr;
        wdata_next  = lat_wdata;
        wstrb_next  = lat_wstrb;
        we_next     = lat_we;
        cnt_next    = '0;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        f_readFin   = 1'b0;
        d_fin       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                grant_data  = pick_data;
                grant_fetch = f_valid && !pick_data;
            end
            ST_GNT_F: begin
                if (mem_fin) begin
                    f_readFin = !f_flush;
                    if (d_req) grant_data = 1'b1;
                    else       state_next = ST_IDLE;
                end else if (f_flush) begin
                    state_next = ST_DRAIN_F;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_GNT_D: begin
                if (mem_fin) begin
                    d_fin = 1'b1;
                    if (f_valid) grant_fetch = 1'b1;
                    else         state_next  = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_DRAIN_F: begin
                if (mem_fin) begin
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_ERR;
                    err_next   = 1'b1;
                end
            end
            ST_ERR: begin
            end
            default: state_next = ST_IDLE;
        endcase

        if (grant_data) begin
            state_next = ST_GNT_D;
            last_next  = SRC_DATA;
            addr_next  = d_addr;
            wdata_next = d_wdata;
            wstrb_next = d_wstrb;
            we_next    = d_we;
        end else if (grant_fetch) begin
            state_next = ST_GNT_F;
            last_next  = SRC_FETCH;
            addr_next  = f_addr;
            wdata_next = '0;
            wstrb_next = '0;
            we_next    = 1'b0;
        end

        // Counter restarts on any state change, so every grant/drain entry begins at 0.
        if (state_next == state && !mem_fin && state != ST_IDLE && state != ST_ERR)
            cnt_next = wait_cnt + CNT_W'(1);
    end

    assign mem_req   = (state == ST_GNT_F) || (state == ST_GNT_D) || (state == ST_DRAIN_F);
    assign mem_we    = (state == ST_GNT_D) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_wstrb = lat_wstrb;
    assign busy      = (state != ST_IDLE);
    assign f_rdata   = rst ? mem_rdata : '0;
    assign d_rdata   = rst ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected memory transactions are queued when
// requests are driven and compared when the memory completes them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ADDR_SIZE = 32;
    localparam int unsigned TIMEOUT   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 f_readEn, f_flush, f_readFin;
    logic [ADDR_SIZE-1:0] f_addr;
    logic [XLEN-1:0]      f_rdata;
    logic                 d_req, d_we, d_fin;
    logic [ADDR_SIZE-1:0] d_addr;
    logic [XLEN-1:0]      d_wdata, d_rdata;
    logic [XLEN/8-1:0]    d_wstrb;
    logic                 mem_req, mem_we, mem_fin;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [XLEN-1:0]      mem_wdata, mem_rdata;
    logic [XLEN/8-1:0]    mem_wstrb;
    logic                 busy, err;

    mem_arbiter #(.XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .f_readEn(f_readEn), .f_addr(f_addr), .f_flush(f_flush),
        .f_readFin(f_readFin), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_fin(d_fin), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_fin(mem_fin), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        fin;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic logic [135:0] observed();
        return {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, f_readFin, d_fin, f_rdata, d_rdata};
    endfunction

    function automatic logic [135:0] expected(input txn_t t);
        return {1'b1, t.we, t.addr, t.wdata, t.wstrb, !t.is_data && t.fin, t.is_data && t.fin,
                t.rdata, t.rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        f_readEn = 0; f_addr = '0; f_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_fin = 0; mem_rdata = 32'hFFFF_FFFF;
        #12;
        total_cnt++;
        if ({busy, err, observed()} !== '0)
            $display("FAIL reset_outputs: got %h want 0", {busy, err, observed()});
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL reset_idle: busy=%b mem_req=%b want 0 0", busy, mem_req);
        else pass_cnt++;
    endtask

    task automatic test_lone_fetch();
        f_readEn = 1; f_addr = 32'h100;
        exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h100, wdata:'0, wstrb:'0,
                          fin:1'b1, rdata:32'hCAFE_0001});
        tick();
        total_cnt++;
        if (mem_req !== 1'b1 || busy !== 1'b1)
            $display("FAIL lone_fetch_latency: mem_req=%b busy=%b want 1 1", mem_req, busy);
        else pass_cnt++;
        f_addr = 32'hBAD0_0BAD;
        repeat (3) tick();
        mem_fin = 1; mem_rdata = 32'hCAFE_0001; f_readEn = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL lone_fetch_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; #1;
        total_cnt++;
        if (busy !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL lone_fetch_idle: busy=%b mem_req=%b want 0 0", busy, mem_req);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        rst = 0; #2; rst = 1;
        f_readEn = 1; f_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        exp_q.push_back('{is_data:1'b1, we:1'b1, addr:32'h2000, wdata:32'hDEAD_BEEF, wstrb:4'hF,
                          fin:1'b1, rdata:32'h1111_0001});
        exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h300, wdata:'0, wstrb:'0,
                          fin:1'b1, rdata:32'h1111_0002});
        tick();
        total_cnt++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h2000})
            $display("FAIL sim_data_first: got %b %b %h want 1 1 00002000", mem_req, mem_we, mem_addr);
        else pass_cnt++;
        tick();
        mem_fin = 1; mem_rdata = 32'h1111_0001; d_req = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL sim_data_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; #1;
        total_cnt++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300} || dut.state !== ST_GNT_F)
            $display("FAIL sim_no_bubble: got %b %b %h state=%0d want 1 0 00000300 state=%0d",
                     mem_req, mem_we, mem_addr, dut.state, ST_GNT_F);
        else pass_cnt++;
        mem_fin = 1; mem_rdata = 32'h1111_0002; f_readEn = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL sim_fetch_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; d_we = 0;
    endtask

    task automatic test_round_robin();
        d_req = 1; d_we = 0; d_addr = 32'h4000; d_wdata = 32'h1111_2222; d_wstrb = 4'h3;
        f_readEn = 1; f_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                exp_q.push_back('{is_data:1'b1, we:1'b0, addr:32'h4000, wdata:32'h1111_2222,
                                  wstrb:4'h3, fin:1'b1, rdata:32'hA000_0000 + i});
            else
                exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h500, wdata:'0, wstrb:'0,
                                  fin:1'b1, rdata:32'hA000_0000 + i});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_fin = 1; mem_rdata = 32'hA000_0000 + i;
            if (i == 3) begin d_req = 0; f_readEn = 0; end
            #1;
            e = exp_q.pop_front(); total_cnt++;
            if (observed() !== expected(e))
                $display("FAIL rr_txn%0d: got %h want %h", i, observed(), expected(e));
            else pass_cnt++;
            tick(); mem_fin = 0;
        end
        #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL rr_idle: busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        f_readEn = 1; f_addr = 32'h600;
        exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h600, wdata:'0, wstrb:'0,
                          fin:1'b0, rdata:32'h5555_0000});
        tick();
        tick();
        f_flush = 1; f_readEn = 0;
        tick();
        f_flush = 0; #1;
        total_cnt++;
        if (dut.state !== ST_DRAIN_F || mem_req !== 1'b1 || f_readFin !== 1'b0)
            $display("FAIL flush_drain: state=%0d mem_req=%b f_readFin=%b want %0d 1 0",
                     dut.state, mem_req, f_readFin, ST_DRAIN_F);
        else pass_cnt++;
        tick();
        mem_fin = 1; mem_rdata = 32'h5555_0000; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL flush_drain_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL flush_idle: busy=%b want 0", busy);
        else pass_cnt++;
        f_readEn = 1; f_addr = 32'h200; f_flush = 1;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL flush_masks_req: busy=%b mem_req=%b want 0 0", busy, mem_req);
        else pass_cnt++;
        f_flush = 0;
        exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h200, wdata:'0, wstrb:'0,
                          fin:1'b1, rdata:32'h2222_0200});
        tick();
        mem_fin = 1; mem_rdata = 32'h2222_0200; f_readEn = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL flush_fresh_fetch: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0;
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h7000; d_wdata = 32'h0BAD_F00D; d_wstrb = 4'hC;
        tick();
        f_readEn = 1; f_addr = 32'h800;
        tick();
        rst = 0; #1;
        total_cnt++;
        if ({mem_req, busy, mem_we, mem_addr, d_fin} !== '0)
            $display("FAIL rst_mid_async: got %b %b %b %h %b want all 0",
                     mem_req, busy, mem_we, mem_addr, d_fin);
        else pass_cnt++;
        rst = 1;
        exp_q.push_back('{is_data:1'b1, we:1'b1, addr:32'h7000, wdata:32'h0BAD_F00D, wstrb:4'hC,
                          fin:1'b1, rdata:32'h7777_0001});
        exp_q.push_back('{is_data:1'b0, we:1'b0, addr:32'h800, wdata:'0, wstrb:'0,
                          fin:1'b1, rdata:32'h7777_0002});
        tick();
        total_cnt++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h7000})
            $display("FAIL rst_data_first: got %b %b %h want 1 1 00007000", mem_req, mem_we, mem_addr);
        else pass_cnt++;
        mem_fin = 1; mem_rdata = 32'h7777_0001; d_req = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL rst_data_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; #1;
        mem_fin = 1; mem_rdata = 32'h7777_0002; f_readEn = 0; #1;
        e = exp_q.pop_front(); total_cnt++;
        if (observed() !== expected(e))
            $display("FAIL rst_fetch_txn: got %h want %h", observed(), expected(e));
        else pass_cnt++;
        tick(); mem_fin = 0; d_we = 0;
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 32'h9000;
        tick();
        d_req = 0;
        repeat (TIMEOUT - 1) tick();
        total_cnt++;
        if (mem_req !== 1'b1 || err !== 1'b0)
            $display("FAIL timeout_last_wait: mem_req=%b err=%b want 1 0", mem_req, err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL timeout_err: err=%b mem_req=%b busy=%b want 1 0 1", err, mem_req, busy);
        else pass_cnt++;
        f_readEn = 1; f_addr = 32'hA00; d_req = 1; mem_fin = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if ({err, mem_req, f_readFin, d_fin} !== 4'b1000)
                $display("FAIL timeout_stuck%0d: got %b want 1000", i, {err, mem_req, f_readFin, d_fin});
            else pass_cnt++;
        end
        f_readEn = 0; d_req = 0; mem_fin = 0;
        rst = 0; #1;
        total_cnt++;
        if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_rst_clear: err=%b busy=%b want 0 0", err, busy);
        else pass_cnt++;
        rst = 1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_round_robin();
        test_flush();
        test_reset_mid();
        test_timeout();
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drained: %0d entries left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: XLEN = 32, data width; ADDR_SIZE = 32, address width; TIMEOUT = 255, maximum wait in cycles for mem_fin.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-003 SHALL have fetch-port ports: f_readEn in 1 fetch read request, held level until served; f_addr in ADDR_SIZE fetch address; f_flush in 1 interrupt_start/redirect; f_readFin out 1 fetch done pulse; f_rdata out XLEN fetch read data.
REQ-004 SHALL have data-port ports: d_req in 1 load/store request, level; d_we in 1 write enable; d_addr in ADDR_SIZE; d_wdata in XLEN; d_wstrb in XLEN/8 byte strobes; d_fin out 1 done pulse; d_rdata out XLEN load data.
REQ-005 SHALL have memory-side ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_SIZE; mem_wdata out XLEN; mem_wstrb out XLEN/8; mem_rdata in XLEN; mem_fin in 1, one-cycle completion pulse.
REQ-006 SHALL have status ports: busy out 1, high when state is not IDLE; err out 1, sticky timeout flag.

Function
REQ-007 SHALL implement the states IDLE, GNT_F, GNT_D, DRAIN_F and ERR.
REQ-008 SHALL, in IDLE, move to GNT_D or GNT_F on the next edge when a request is pending, latching that requester's address, write data, strobes and we.
REQ-009 SHALL resolve simultaneous requests round-robin: the requester not served last wins; after reset, d_req has priority.
REQ-010 SHALL hold mem_req = 1 in GNT_F, GNT_D and DRAIN_F and drive mem_addr, mem_wdata, mem_wstrb and mem_we only from the latched registers; mem_we = 0 in GNT_F.
REQ-011 SHALL drive f_readFin = mem_fin in GNT_F and d_fin = mem_fin in GNT_D, combinationally in the same cycle; f_rdata and d_rdata = mem_rdata pass-through.
REQ-012 SHALL decide the next state on mem_fin: GNT_other if the other requester is pending that cycle (latching its fields), else IDLE; the just-served requester is never re-granted on the same edge.
REQ-013 SHALL, when f_flush is high in GNT_F without mem_fin, move to DRAIN_F; in DRAIN_F, f_readFin SHALL stay 0, and mem_fin SHALL return the state to IDLE.
REQ-014 SHALL, when f_flush coincides with mem_fin in GNT_F, suppress f_readFin and follow REQ-012.
REQ-015 SHALL ignore f_readEn in any cycle where f_flush is high; f_flush has no effect on GNT_D.
REQ-016 SHALL count wait cycles in each grant or drain state, clearing the count on entry and on mem_fin; reaching TIMEOUT SHALL set err and move to ERR.
REQ-017 SHALL, in ERR, keep mem_req = 0 and all fin outputs at 0, leaving ERR only on reset.
REQ-018 SHALL give one-cycle minimum request-to-mem_req latency from IDLE, and zero bubble between back-to-back grants to different requesters.
REQ-019 SHALL assert busy = 1 in GNT_F, GNT_D, DRAIN_F and ERR.

Reset
REQ-020 SHALL, on rst low and asynchronously, set the state to IDLE, the last-served requester to fetch (so data wins first), the wait count to 0, err to 0 and the latched address, data and strobe registers to 0.
REQ-021 SHALL hold all outputs at 0 during reset; mem_req SHALL deassert immediately, and a transaction in flight is abandoned.
REQ-022 SHALL leave reset release synchronous to clk; the first request is sampled on the first edge after release.

Structure
REQ-023 SHALL place the state encoding (3-bit: IDLE=000, GNT_F=001, GNT_D=010, DRAIN_F=011, ERR=100) and the TIMEOUT default in the shared pipeline package alongside the fetch and decode state constants.
REQ-024 SHALL be a single module with no sub-module; the timeout counter is inline, sized as clog2(TIMEOUT+1).

Verification
REQ-025 SHALL test a lone fetch: f_readEn with f_addr=0x100 and mem_fin 3 cycles after grant -> mem_req on cycle 1, mem_addr=0x100, f_readFin pulse with f_rdata=mem_rdata, then IDLE.
REQ-026 SHALL test a simultaneous request after reset: f_readEn, and d_req with we=1, addr=0x2000, wdata=0xDEADBEEF and wstrb=0xF -> data granted first, mem_we=1; on its mem_fin, GNT_F follows with no IDLE cycle.
REQ-027 SHALL test round-robin: both requesters held high for 4 transactions -> grants alternate D,F,D,F.
REQ-028 SHALL test flush mid-fetch: f_flush 1 cycle after GNT_F, mem_fin 2 cycles later -> state goes to DRAIN_F, no f_readFin, then IDLE; a fresh fetch to 0x200 is then served.
REQ-029 SHALL test timeout with TIMEOUT=8: mem_fin is never asserted -> err=1 after 8 grant cycles, and mem_req drops and stays 0 until rst.
REQ-030 SHALL test reset mid-GNT_D: rst low -> mem_req=0 immediately, and after release a pending f_readEn is granted (data-first priority reset).
